// File: rtl/alu_issue_decoder_pkg.sv
// Shared ALU op codes, RV32I opcode and funct7 constants for the ALU issue path.
package alu_issue_decoder_pkg;

    typedef enum logic [5:0] {
        ALU_OP_PLUS            = 6'd0,
        ALU_OP_SUB             = 6'd1,
        ALU_OP_SHIFT_LEFT      = 6'd2,
        ALU_OP_SET_LESS_THAN   = 6'd3,
        ALU_OP_SET_LESS_THAN_U = 6'd4,
        ALU_OP_XOR             = 6'd5,
        ALU_OP_SHIFT_RIGHT     = 6'd6,
        ALU_OP_SHIFT_RIGHT_A   = 6'd7,
        ALU_OP_OR              = 6'd8,
        ALU_OP_AND             = 6'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB for f3=000 and arithmetic shift for f3=101
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_OP_SUB : ALU_OP_PLUS;
            3'b001:  op = ALU_OP_SHIFT_LEFT;
            3'b010:  op = ALU_OP_SET_LESS_THAN;
            3'b011:  op = ALU_OP_SET_LESS_THAN_U;
            3'b100:  op = ALU_OP_XOR;
            3'b101:  op = alt ? ALU_OP_SHIFT_RIGHT_A : ALU_OP_SHIFT_RIGHT;
            3'b110:  op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_decoder_op_decode.sv
// Pure combinational decode of an RV32I ALU-class instruction into alu_op and operands.
module alu_op_decode
    import alu_issue_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    input  logic [31:0]           pc,
    output logic [5:0]            alu_op,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic [4:0]            rd,
    output logic                  illegal
);

    logic [6:0]             opc;
    logic [2:0]             f3;
    logic [6:0]             f7;
    logic signed [11:0]     imm_i;
    logic signed [31:0]     imm_u;
    logic [DATA_WIDTH-1:0]  imm_i_sx;
    logic [DATA_WIDTH-1:0]  imm_u_sx;
    logic [DATA_WIDTH-1:0]  shamt_zx;
    logic [DATA_WIDTH-1:0]  pc_zx;
    alu_op_e                op;
    logic [DATA_WIDTH-1:0]  a_d;
    logic [DATA_WIDTH-1:0]  b_d;
    logic                   legal;

    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign imm_i    = instr[31:20];
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_i_sx = DATA_WIDTH'(imm_i);
    assign imm_u_sx = DATA_WIDTH'(imm_u);
    assign shamt_zx = DATA_WIDTH'(instr[24:20]);
    assign pc_zx    = DATA_WIDTH'(pc);

    always_comb begin
        op    = ALU_OP_PLUS;
        a_d   = '0;
        b_d   = '0;
        legal = 1'b0;
        case (opc)
            OPC_OP: begin
                a_d   = rs1;
                b_d   = rs2;
                op    = f3_to_op(f3, f7 == F7_ALT);
                legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                a_d = rs1;
                // ADDI never becomes SUB; only SRAI uses the alternate funct7
                op  = f3_to_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                if (f3 == 3'b001) begin
                    b_d   = shamt_zx;
                    legal = (f7 == F7_BASE);
                end else if (f3 == 3'b101) begin
                    b_d   = shamt_zx;
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                end else begin
                    b_d   = imm_i_sx;
                    legal = 1'b1;
                end
            end
            OPC_LUI: begin
                b_d   = imm_u_sx;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                a_d   = pc_zx;
                b_d   = imm_u_sx;
                legal = 1'b1;
            end
            default: ;
        endcase
    end

    // Illegal entries are normalised so the consumer sees a harmless PLUS 0,0 -> x0
    assign illegal = !legal;
    assign alu_op  = legal ? op : ALU_OP_PLUS;
    assign a       = legal ? a_d : '0;
    assign b       = legal ? b_d : '0;
    assign rd      = legal ? instr[11:7] : 5'd0;

endmodule

// File: rtl/alu_issue_decoder.sv
// ALU issue stage: decode + registered output stage driving the ALU (E/alu_op/A/B).
// Optional 2-entry skid buffer enabled by defining ALU_ISSUE_SKID_EN.
module alu_issue_decoder
    import alu_issue_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_rs1,
    input  logic [DATA_WIDTH-1:0] in_rs2,
    input  logic [31:0]           in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_alu_op,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [4:0]            out_rd,
    output logic                  out_illegal
);

    localparam int ENT_W = 6 + 2 * DATA_WIDTH + 5 + 1;

    logic [5:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic [4:0]            dec_rd;
    logic                  dec_ill;

    logic [ENT_W-1:0] ent_p0;
    logic [ENT_W-1:0] ent_p1;
    logic             vld_p1;
    logic             in_fire;
    logic             out_fire;

    alu_op_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .instr   (in_instr),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .pc      (in_pc),
        .alu_op  (dec_op),
        .a       (dec_a),
        .b       (dec_b),
        .rd      (dec_rd),
        .illegal (dec_ill)
    );

    // ---- stage p0: decoded entry ----
    assign ent_p0   = {dec_op, dec_a, dec_b, dec_rd, dec_ill};
    assign out_fire = vld_p1 & out_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic [ENT_W-1:0] ent_sk;
    logic             vld_sk;
    logic             in_rdy_q;

    assign in_ready = in_rdy_q;
    assign in_fire  = in_valid & in_rdy_q;

    // ---- stage p1: output register with skid entry behind it ----
    // in_rdy_q mirrors !vld_sk, so the skid entry is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            ent_p1   <= '0;
            vld_sk   <= 1'b0;
            ent_sk   <= '0;
            in_rdy_q <= 1'b1;
        end else if (!vld_p1 || out_fire) begin
            if (vld_sk) begin
                vld_p1 <= 1'b1;
                ent_p1 <= ent_sk;
            end else if (in_fire) begin
                vld_p1 <= 1'b1;
                ent_p1 <= ent_p0;
            end else begin
                vld_p1 <= 1'b0;
            end
            vld_sk   <= 1'b0;
            in_rdy_q <= 1'b1;
        end else if (in_fire) begin
            vld_sk   <= 1'b1;
            ent_sk   <= ent_p0;
            in_rdy_q <= 1'b0;
        end
    end
`else
    assign in_ready = !vld_p1 | out_ready;
    assign in_fire  = in_valid & in_ready;

    // ---- stage p1: single output register, replaced in the cycle it drains ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            ent_p1 <= '0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
            ent_p1 <= ent_p0;
        end else if (out_fire) begin
            vld_p1 <= 1'b0;
        end
    end
`endif

    assign out_valid = vld_p1;
    assign {out_alu_op, out_a, out_b, out_rd, out_illegal} = ent_p1;

endmodule
